// File: rtl/core_sequencer_pkg.sv
// Shared types and encodings for the multi-cycle core sequencer and its decoder.
package core_sequencer_pkg;

    // Core configuration consumed by the datapath; the sequencer only sanity-checks it.
    typedef struct packed {
        logic [7:0]  xlen;
        logic [31:0] reset_pc;
    } config_t;

    localparam config_t CONF_DEFAULT = '{xlen: 8'd32, reset_pc: 32'h0000_0000};

    typedef logic [6:0] opcode_t;
    typedef logic [2:0] funct3_t;
    typedef logic [6:0] funct7_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SRL  = 3'd4,
        ALU_SLTU = 3'd5
    } alu_op_t;

    typedef enum logic [2:0] {
        SEQ_BOOT   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_WB     = 3'd5,
        SEQ_HALT   = 3'd6
    } seq_state_t;

    typedef enum logic [2:0] {
        ALU_R   = 3'd0,
        ALU_I   = 3'd1,
        LUI     = 3'd2,
        BRANCH  = 3'd3,
        LOAD    = 3'd4,
        STORE   = 3'd5,
        ILLEGAL = 3'd6
    } instr_class_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_cause_t;

    // Major opcodes (RV32I encodings)
    localparam opcode_t OP_LUI    = 7'b0110111;
    localparam opcode_t OP_OP     = 7'b0110011;
    localparam opcode_t OP_IMM    = 7'b0010011;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_LW     = 7'b0000011;
    localparam opcode_t OP_SW     = 7'b0100011;

    localparam funct3_t FUNCT3_ADD_SUB = 3'b000;
    localparam funct3_t FUNCT3_SLTU    = 3'b011;
    localparam funct3_t FUNCT3_SRL     = 3'b101;
    localparam funct3_t FUNCT3_OR      = 3'b110;
    localparam funct3_t FUNCT3_ADDI    = 3'b000;
    localparam funct3_t FUNCT3_ANDI    = 3'b111;
    localparam funct3_t FUNCT3_BEQ     = 3'b000;
    localparam funct3_t FUNCT3_BNE     = 3'b001;
    localparam funct3_t FUNCT3_LW      = 3'b010;
    localparam funct3_t FUNCT3_SW      = 3'b010;

    localparam funct7_t FUNCT7_BASE = 7'b0000000;
    localparam funct7_t FUNCT7_ALT  = 7'b0100000;

    // Classes whose second ALU operand is the immediate
    function automatic logic uses_imm(input instr_class_t c);
        return (c == ALU_I) || (c == LOAD) || (c == STORE);
    endfunction

endpackage

// File: rtl/core_sequencer_instr_class.sv
// Combinational instruction classifier: op/funct3/funct7 -> class, ALU op, branch polarity.
module core_instr_class
    import core_sequencer_pkg::*;
(
    input  opcode_t      op,
    input  funct3_t      funct3,
    input  funct7_t      funct7,
    output instr_class_t instr_class,
    output alu_op_t      alu_op,
    output logic         branch_ne
);

    // Anything not explicitly recognised falls through as ILLEGAL
    always_comb begin
        instr_class = ILLEGAL;
        alu_op      = ALU_ADD;
        branch_ne   = 1'b0;
        case (op)
            OP_OP: begin
                if (funct7 == FUNCT7_BASE) begin
                    case (funct3)
                        FUNCT3_ADD_SUB: begin instr_class = ALU_R; alu_op = ALU_ADD;  end
                        FUNCT3_OR:      begin instr_class = ALU_R; alu_op = ALU_OR;   end
                        FUNCT3_SRL:     begin instr_class = ALU_R; alu_op = ALU_SRL;  end
                        FUNCT3_SLTU:    begin instr_class = ALU_R; alu_op = ALU_SLTU; end
                        default:        ;
                    endcase
                end else if (funct7 == FUNCT7_ALT && funct3 == FUNCT3_ADD_SUB) begin
                    instr_class = ALU_R;
                    alu_op      = ALU_SUB;
                end
            end
            OP_IMM: begin
                case (funct3)
                    FUNCT3_ADDI: begin instr_class = ALU_I; alu_op = ALU_ADD; end
                    FUNCT3_ANDI: begin instr_class = ALU_I; alu_op = ALU_AND; end
                    default:     ;
                endcase
            end
            OP_LUI: begin
                instr_class = LUI;
            end
            OP_BRANCH: begin
                case (funct3)
                    FUNCT3_BEQ: begin instr_class = BRANCH; alu_op = ALU_SUB; end
                    FUNCT3_BNE: begin instr_class = BRANCH; alu_op = ALU_SUB; branch_ne = 1'b1; end
                    default:    ;
                endcase
            end
            OP_LW: begin
                if (funct3 == FUNCT3_LW) instr_class = LOAD;
            end
            OP_SW: begin
                if (funct3 == FUNCT3_SW) instr_class = STORE;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM sharing one memory port between fetch and data access.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter config_t     CONF           = CONF_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  opcode_t    op,
    input  funct3_t    funct3,
    input  funct7_t    funct7,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       reg_write,
    output logic       alu_src,
    output logic       wd_src,
    output logic       mem_to_reg,
    output alu_op_t    alu_op,
    output logic       retire,
    output logic       halted,
    output logic [1:0] err_cause
);

    localparam logic [2:0] ST_BOOT   = SEQ_BOOT;
    localparam logic [2:0] ST_FETCH  = SEQ_FETCH;
    localparam logic [2:0] ST_DECODE = SEQ_DECODE;
    localparam logic [2:0] ST_EXEC   = SEQ_EXEC;
    localparam logic [2:0] ST_MEM    = SEQ_MEM;
    localparam logic [2:0] ST_WB     = SEQ_WB;
    localparam logic [2:0] ST_HALT   = SEQ_HALT;

    // Wait counter sized to hold TIMEOUT_CYCLES; a zero timeout disables the check
    localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam int              CNT_W    = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    // The sequencer only supports the two standard integer widths
    generate
        if (CONF.xlen != 8'd32 && CONF.xlen != 8'd64) begin : g_bad_conf
            $error("core_sequencer: unsupported XLEN in CONF");
        end
    endgenerate

    logic [2:0]       state_reg, state_next;
    instr_class_t     class_reg;
    alu_op_t          alu_op_reg;
    logic             branch_ne_reg;
    err_cause_t       err_reg, err_next;
    logic [CNT_W-1:0] count_reg;

    instr_class_t dec_class;
    alu_op_t      dec_alu_op;
    logic         dec_branch_ne;

    logic in_xfer;
    logic handshake;
    logic timeout_hit;
    logic branch_taken;

    core_instr_class u_instr_class (
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .instr_class (dec_class),
        .alu_op      (dec_alu_op),
        .branch_ne   (dec_branch_ne)
    );

    // rst blocks the handshake so an abandoned transfer never commits a strobe
    assign in_xfer      = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
    assign handshake    = in_xfer && mem_ready && !rst;
    assign timeout_hit  = TMO_EN && in_xfer && !mem_ready && (count_reg == CNT_LAST);
    assign branch_taken = branch_ne_reg ? !alu_zero : alu_zero;
    assign halted       = (state_reg == ST_HALT);
    assign err_cause    = err_reg;

    // Next-state and error-cause selection
    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_BOOT:   state_next = ST_FETCH;
            ST_FETCH: begin
                if (handshake) begin
                    state_next = ST_DECODE;
                end else if (timeout_hit) begin
                    state_next = ST_HALT;
                    err_next   = ERR_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (dec_class)
                    LUI:     state_next = ST_WB;
                    ILLEGAL: begin
                        state_next = ST_HALT;
                        err_next   = ERR_ILLEGAL;
                    end
                    default: state_next = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (class_reg)
                    ALU_R, ALU_I: state_next = ST_WB;
                    LOAD, STORE:  state_next = ST_MEM;
                    default:      state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (handshake) begin
                    state_next = (class_reg == STORE) ? ST_FETCH : ST_WB;
                end else if (timeout_hit) begin
                    state_next = ST_HALT;
                    err_next   = ERR_TIMEOUT;
                end
            end
            ST_WB:     state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_BOOT;
        endcase
    end

    // State register plus the decode results captured while in DECODE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_BOOT;
            class_reg     <= ILLEGAL;
            alu_op_reg    <= ALU_ADD;
            branch_ne_reg <= 1'b0;
            err_reg       <= ERR_NONE;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (state_reg == ST_DECODE) begin
                class_reg     <= dec_class;
                alu_op_reg    <= dec_alu_op;
                branch_ne_reg <= dec_branch_ne;
            end
        end
    end

    // Wait-cycle counter: zero outside a transfer, saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || !in_xfer || handshake) begin
            count_reg <= '0;
        end else if (!mem_ready && count_reg != CNT_LAST) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Moore control outputs; commit strobes are suppressed while rst is high
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        reg_write    = 1'b0;
        alu_src      = 1'b0;
        wd_src       = 1'b0;
        mem_to_reg   = 1'b0;
        alu_op       = ALU_ADD;
        retire       = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = handshake;
                pc_we   = handshake;
            end
            ST_EXEC: begin
                alu_op  = alu_op_reg;
                alu_src = uses_imm(class_reg);
                if (class_reg == BRANCH) begin
                    pc_we  = branch_taken && !rst;
                    pc_src = branch_taken;
                    retire = !rst;
                end
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (class_reg == STORE);
                alu_src      = 1'b1;
                alu_op       = alu_op_reg;
                retire       = handshake && (class_reg == STORE);
            end
            ST_WB: begin
                reg_write  = !rst;
                retire     = !rst;
                mem_to_reg = (class_reg == LOAD);
                wd_src     = (class_reg == LUI);
                alu_src    = uses_imm(class_reg);
                alu_op     = alu_op_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Randomised instruction stream checked cycle-by-cycle against a per-instruction phase model.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    localparam int TMO   = 4;
    localparam int N_ENT = 20;

    logic       clk = 1'b0;
    logic       rst;
    opcode_t    op;
    funct3_t    funct3;
    funct7_t    funct7;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src;
    logic       reg_write, alu_src, wd_src, mem_to_reg, retire, halted;
    alu_op_t    alu_op;
    logic [1:0] err_cause;

    core_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .op           (op),
        .funct3       (funct3),
        .funct7       (funct7),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .alu_src      (alu_src),
        .wd_src       (wd_src),
        .mem_to_reg   (mem_to_reg),
        .alu_op       (alu_op),
        .retire       (retire),
        .halted       (halted),
        .err_cause    (err_cause)
    );

    always #5 clk = ~clk;

    // Output bundle: {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_write,
    //                 alu_src, wd_src, mem_to_reg, alu_op[2:0], retire, halted, err[1:0]}
    logic [16:0] obs;
    assign obs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_write,
                  alu_src, wd_src, mem_to_reg, alu_op, retire, halted, err_cause};

    localparam logic [16:0] V_MEM_REQ = 17'h10000;
    localparam logic [16:0] V_MEM_WE  = 17'h08000;
    localparam logic [16:0] V_ADDR    = 17'h04000;
    localparam logic [16:0] V_IR_WE   = 17'h02000;
    localparam logic [16:0] V_PC_WE   = 17'h01000;
    localparam logic [16:0] V_PC_SRC  = 17'h00800;
    localparam logic [16:0] V_REG_WR  = 17'h00400;
    localparam logic [16:0] V_ALU_SRC = 17'h00200;
    localparam logic [16:0] V_WD      = 17'h00100;
    localparam logic [16:0] V_M2R     = 17'h00080;
    localparam logic [16:0] V_ALU_OP  = 17'h00070;
    localparam logic [16:0] V_RET     = 17'h00008;
    localparam logic [16:0] V_HALT    = 17'h00004;
    localparam logic [16:0] M_ALL     = 17'h1FFFF;
    localparam logic [16:0] M_NO_ALU  = M_ALL & ~(V_ALU_SRC | V_ALU_OP);
    localparam logic [16:0] M_NO_SRC  = M_ALL & ~V_ALU_SRC;

    typedef struct packed {
        opcode_t      op;
        funct3_t      f3;
        funct7_t      f7;
        logic         any_f3;
        logic         any_f7;
        instr_class_t cls;
        alu_op_t      aop;
        logic         ne;
    } ent_t;

    string names [N_ENT] = '{"ADD", "SUB", "OR", "SRL", "SLTU", "ADDI", "ANDI", "LUI",
                             "BEQ", "BNE", "LW", "SW", "ILL_7F", "ILL_MUL", "ILL_SRA",
                             "ILL_AND", "ILL_BLT", "ILL_LB", "ILL_SB", "ILL_SLLI"};

    int n_checks = 0;
    int n_fail   = 0;
    int n_instr  = 0;
    int exp_retire = 0;
    int n_retire_obs = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input opcode_t o, input funct3_t f3, input funct7_t f7,
                                input logic a3, input logic a7, input instr_class_t c,
                                input alu_op_t a, input logic ne);
        ent_t e;
        e.op = o; e.f3 = f3; e.f7 = f7; e.any_f3 = a3; e.any_f7 = a7;
        e.cls = c; e.aop = a; e.ne = ne;
        return e;
    endfunction

    // Reference instruction table: encodings and expected meaning, written out by hand
    function automatic ent_t ent(input int k);
        case (k)
            0:  return mk(7'b0110011, 3'b000, 7'b0000000, 0, 0, ALU_R,   ALU_ADD,  0);
            1:  return mk(7'b0110011, 3'b000, 7'b0100000, 0, 0, ALU_R,   ALU_SUB,  0);
            2:  return mk(7'b0110011, 3'b110, 7'b0000000, 0, 0, ALU_R,   ALU_OR,   0);
            3:  return mk(7'b0110011, 3'b101, 7'b0000000, 0, 0, ALU_R,   ALU_SRL,  0);
            4:  return mk(7'b0110011, 3'b011, 7'b0000000, 0, 0, ALU_R,   ALU_SLTU, 0);
            5:  return mk(7'b0010011, 3'b000, 7'b0000000, 0, 1, ALU_I,   ALU_ADD,  0);
            6:  return mk(7'b0010011, 3'b111, 7'b0000000, 0, 1, ALU_I,   ALU_AND,  0);
            7:  return mk(7'b0110111, 3'b000, 7'b0000000, 1, 1, LUI,     ALU_ADD,  0);
            8:  return mk(7'b1100011, 3'b000, 7'b0000000, 0, 1, BRANCH,  ALU_SUB,  0);
            9:  return mk(7'b1100011, 3'b001, 7'b0000000, 0, 1, BRANCH,  ALU_SUB,  1);
            10: return mk(7'b0000011, 3'b010, 7'b0000000, 0, 1, LOAD,    ALU_ADD,  0);
            11: return mk(7'b0100011, 3'b010, 7'b0000000, 0, 1, STORE,   ALU_ADD,  0);
            12: return mk(7'b1111111, 3'b000, 7'b0000000, 1, 1, ILLEGAL, ALU_ADD,  0);
            13: return mk(7'b0110011, 3'b000, 7'b0000001, 0, 0, ILLEGAL, ALU_ADD,  0);
            14: return mk(7'b0110011, 3'b101, 7'b0100000, 0, 0, ILLEGAL, ALU_ADD,  0);
            15: return mk(7'b0110011, 3'b111, 7'b0000000, 0, 0, ILLEGAL, ALU_ADD,  0);
            16: return mk(7'b1100011, 3'b100, 7'b0000000, 0, 1, ILLEGAL, ALU_ADD,  0);
            17: return mk(7'b0000011, 3'b000, 7'b0000000, 0, 1, ILLEGAL, ALU_ADD,  0);
            18: return mk(7'b0100011, 3'b000, 7'b0000000, 0, 1, ILLEGAL, ALU_ADD,  0);
            default: return mk(7'b0010011, 3'b001, 7'b0000000, 0, 1, ILLEGAL, ALU_ADD, 0);
        endcase
    endfunction

    function automatic logic [16:0] aop_bits(input alu_op_t a);
        return {10'b0, a, 4'b0};
    endfunction

    task automatic drive_junk();
        op       = 7'($urandom);
        funct3   = 3'($urandom);
        funct7   = 7'($urandom);
        alu_zero = 1'($urandom);
    endtask

    // One clock cycle: compare outputs on the falling edge, then move past the next rising edge
    task automatic step(input string tag, input logic [16:0] exp, input logic [16:0] mask);
        @(negedge clk);
        check(tag, {15'b0, obs & mask}, {15'b0, exp & mask});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'($urandom);
        drive_junk();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("boot", 17'h0, M_ALL);
    endtask

    task automatic halt_seq(input logic [1:0] err, input string tag);
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom);
            drive_junk();
            step(tag, V_HALT | {15'b0, err}, M_NO_ALU);
        end
        do_reset();
    endtask

    // Runs one instruction from its FETCH cycle; always leaves the sequencer about to FETCH
    task automatic run_instr(input int k, input int fw, input int mw, input logic zero,
                             input logic rst_in_mem);
        ent_t        e;
        logic        rdy;
        logic        taken;
        logic [16:0] exp;
        logic [16:0] mask;
        e = ent(k);
        n_instr++;
        $display("instr %0d: %s fetch_wait=%0d mem_wait=%0d alu_zero=%0d rst_in_mem=%0d",
                 n_instr, names[k], fw, mw, zero, rst_in_mem);

        for (int i = 0; i <= fw; i++) begin
            rdy = (i == fw);
            drive_junk();
            mem_ready = rdy;
            step("fetch", V_MEM_REQ | (rdy ? (V_IR_WE | V_PC_WE) : 17'h0), M_NO_ALU);
            if (!rdy && i + 1 == TMO) begin
                halt_seq(2'b10, "halt_fetch_timeout");
                return;
            end
        end

        op        = e.op;
        funct3    = e.any_f3 ? 3'($urandom) : e.f3;
        funct7    = e.any_f7 ? 7'($urandom) : e.f7;
        alu_zero  = 1'($urandom);
        mem_ready = 1'($urandom);
        step("decode", 17'h0, M_NO_ALU);
        if (e.cls == ILLEGAL) begin
            halt_seq(2'b01, "halt_illegal");
            return;
        end

        if (e.cls != LUI) begin
            mem_ready = 1'($urandom);
            alu_zero  = (e.cls == BRANCH) ? zero : 1'($urandom);
            mask      = M_ALL;
            case (e.cls)
                ALU_R:  exp = aop_bits(e.aop);
                ALU_I:  exp = V_ALU_SRC | aop_bits(e.aop);
                BRANCH: begin
                    taken = e.ne ? !zero : zero;
                    exp   = aop_bits(ALU_SUB) | V_RET | (taken ? (V_PC_WE | V_PC_SRC) : 17'h0);
                    mask  = M_NO_SRC;
                end
                default: exp = V_ALU_SRC | aop_bits(ALU_ADD);
            endcase
            step("exec", exp, mask);
            if (e.cls == BRANCH) begin
                exp_retire++;
                return;
            end
        end

        if (e.cls == LOAD || e.cls == STORE) begin
            for (int i = 0; i <= mw; i++) begin
                rdy       = (i == mw);
                mem_ready = rdy;
                alu_zero  = 1'($urandom);
                exp = V_MEM_REQ | V_ADDR | V_ALU_SRC | aop_bits(ALU_ADD)
                    | ((e.cls == STORE) ? V_MEM_WE : 17'h0);
                if (rst_in_mem && i == 1) begin
                    mem_ready = 1'b0;
                    rst       = 1'b1;
                    step("mem_under_rst", exp, M_ALL);
                    rst = 1'b0;
                    step("boot_after_rst", 17'h0, M_ALL);
                    return;
                end
                if (e.cls == STORE && rdy) exp = exp | V_RET;
                step("mem", exp, M_ALL);
                if (!rdy && i + 1 == TMO) begin
                    halt_seq(2'b10, "halt_mem_timeout");
                    return;
                end
            end
            if (e.cls == STORE) begin
                exp_retire++;
                return;
            end
        end

        mem_ready = 1'($urandom);
        alu_zero  = 1'($urandom);
        exp = V_REG_WR | V_RET
            | ((e.cls == LOAD) ? V_M2R : 17'h0)
            | ((e.cls == LUI) ? V_WD : 17'h0)
            | ((e.cls == ALU_I || e.cls == LOAD) ? V_ALU_SRC : 17'h0)
            | aop_bits(e.aop);
        step("wb", exp, (e.cls == LUI) ? M_NO_ALU : M_ALL);
        exp_retire++;
    endtask

    always @(negedge clk) begin
        if (retire === 1'b1) n_retire_obs++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit, expected summary before it");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, fw, mw;
        rst       = 1'b1;
        mem_ready = 1'b0;
        op        = '0;
        funct3    = '0;
        funct7    = '0;
        alu_zero  = 1'b0;
        do_reset();

        run_instr(5, 0, 0, 1'b0, 1'b0);    // ADDI
        run_instr(0, 0, 0, 1'b0, 1'b0);    // ADD
        run_instr(8, 0, 0, 1'b1, 1'b0);    // BEQ taken
        run_instr(9, 0, 0, 1'b1, 1'b0);    // BNE not taken
        run_instr(10, 0, 3, 1'b0, 1'b0);   // LW, three wait cycles in MEM
        run_instr(0, 9, 0, 1'b0, 1'b0);    // fetch never answers -> timeout
        run_instr(12, 0, 0, 1'b0, 1'b0);   // opcode 7F -> illegal
        run_instr(11, 0, 3, 1'b0, 1'b1);   // SW reset mid-transfer
        run_instr(11, 1, 5, 1'b0, 1'b0);   // SW data phase timeout
        run_instr(7, 2, 0, 1'b0, 1'b0);    // LUI with fetch waits
        run_instr(10, 3, 0, 1'b0, 1'b0);   // LW, longest legal fetch wait

        for (int n = 0; n < 300; n++) begin
            k  = int'($urandom_range(0, N_ENT - 1));
            fw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TMO, TMO + 2))
                                              : int'($urandom_range(0, TMO - 1));
            mw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TMO, TMO + 2))
                                              : int'($urandom_range(0, TMO - 1));
            run_instr(k, fw, mw, 1'($urandom), 1'b0);
        end

        check("retire_count", n_retire_obs, exp_retire);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
